multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 138 +++++++++++++
 tb/tb_multicycle_control.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM with Mealy pcen/irwrite.
// Optional BNE support enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       pcen,
  output logic       illegal,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  state_t state_q, state_d;
  logic   pcen_c, irwrite_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    irwrite_c  = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    pcen_c     = 1'b0;
    illegal    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = memready;
        pcen_c    = memready;
        state_d   = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      illegal = 1'b1;
        endcase
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (state_q == ADDIEX) state_d = ADDIWB;
        else                   state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = memready ? FETCH : MEMWR;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        state_d = RTYPEWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   illegal    = 1'b1;
        endcase
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB:  regwrite = 1'b1;
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen_c     = (state_q == BEQEX) ? zero : ~zero;
      end
      JEX: begin
        pcsrc  = 2'b10;
        pcen_c = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // State is already FETCH during reset, but the memready-driven enables must be forced low.
  assign pcen    = pcen_c & reset;
  assign irwrite = irwrite_c & reset;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed literal checks, then
// randomized stimulus against an instruction-plan model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .pcen(pcen),
    .illegal(illegal), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
  } outs_t;

  outs_t dut_o;
  assign dut_o = '{iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, pcen,
                   illegal, alusrcb, pcsrc, alucontrol, state};

`ifdef MULTICYCLE_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  // Model: whole-instruction state plans, chosen once the opcode is known.
  int mstate;
  int plan[$];

  function automatic bit legal_op(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
           o == 6'b001000 || o == 6'b000010 || (BNE_EN && o == 6'b000101);
  endfunction

  function automatic outs_t model_out(input int s, input logic rst_n, input logic mr,
                                      input logic z, input logic [5:0] o, input logic [5:0] f);
    outs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    e.state = 4'(s);
    if (!rst_n) begin
      e.alusrcb = 2'b01;
      e.state = 4'd0;
      return e;
    end
    case (s)
      0:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      1:  begin e.alusrcb = 2'b11; e.illegal = !legal_op(o); end
      2, 9: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.memtoreg = 1; e.regwrite = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6:  begin
            e.alusrca = 1;
            if      (f == 6'b100010) e.alucontrol = 3'b110;
            else if (f == 6'b100100) e.alucontrol = 3'b000;
            else if (f == 6'b100101) e.alucontrol = 3'b001;
            else if (f == 6'b101010) e.alucontrol = 3'b111;
            else if (f != 6'b100000) e.illegal = 1;
          end
      7:  begin e.regdst = 1; e.regwrite = 1; end
      10: e.regwrite = 1;
      8, 12: begin
            e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
            e.pcen = (s == 8) ? z : !z;
          end
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_advance();
    if (mstate == 0) begin
      if (memready) mstate = 1;
    end else if (mstate == 1) begin
      plan.delete();
      case (op)
        6'b100011: plan = '{2, 3, 4};
        6'b101011: plan = '{2, 5};
        6'b000000: plan = '{6, 7};
        6'b000100: plan = '{8};
        6'b001000: plan = '{9, 10};
        6'b000010: plan = '{11};
        6'b000101: if (BNE_EN) plan = '{12};
        default: ;
      endcase
      mstate = (plan.size() != 0) ? plan.pop_front() : 0;
    end else if ((mstate == 3 || mstate == 5) && !memready) begin
      mstate = mstate;
    end else begin
      mstate = (plan.size() != 0) ? plan.pop_front() : 0;
    end
  endtask

  task automatic check_model(input string name);
    outs_t e;
    e = model_out(mstate, reset, memready, zero, op, funct);
    checks++;
    if (dut_o !== e) begin
      errors++;
      $display("FAIL %s t=%0t op=%b funct=%b mr=%b z=%b got=%h expected=%h",
               name, $time, op, funct, memready, zero, dut_o, e);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; op = 6'b100011; funct = 6'b100000; zero = 1'b0; memready = 1'b1;
    #2;
    // reset state with memready high
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_en", 16'({irwrite, pcen, regwrite, memwrite, illegal}), 16'd0);
    chk("rst_mux", 16'({alusrcb, pcsrc, alucontrol}), 16'b01_00_010);
    tick(); tick();
    reset = 1'b1;
    #1;
    // lw
    chk("lw_fetch", 16'({state, pcen, irwrite}), 16'b0000_1_1);
    tick(); chk("lw_s1", 16'({state, pcen}), 16'b0001_0);
    tick(); chk("lw_s2", 16'({state, alusrca, alusrcb}), 16'b0010_1_10);
    tick(); chk("lw_s3", 16'({state, iord, regwrite, pcen}), 16'b0011_1_0_0);
    tick(); chk("lw_s4", 16'({state, regwrite, memtoreg, pcen}), 16'b0100_1_1_0);
    tick(); chk("lw_back", 16'(state), 16'd0);
    // sw with 3 stall cycles
    op = 6'b101011;
    tick(); tick(); tick();
    memready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall", 16'({state, memwrite, regwrite}), 16'b0101_1_0);
      tick();
    end
    memready = 1'b1;
    #1;
    chk("sw_last", 16'({state, memwrite, regwrite}), 16'b0101_1_0);
    tick(); chk("sw_done", 16'({state, memwrite}), 16'b0000_0);
    // R-type slt, then illegal funct
    op = 6'b000000; funct = 6'b101010;
    tick(); tick();
    chk("r_ex", 16'({state, alucontrol, illegal}), 16'b0110_111_0);
    tick(); chk("r_wb", 16'({state, regdst, regwrite}), 16'b0111_1_1);
    funct = 6'b111111;
    tick(); tick(); tick();
    chk("r_bad", 16'({state, illegal, alucontrol}), 16'b0110_1_010);
    tick(); chk("r_bad_wb", 16'({state, illegal}), 16'b0111_0);
    // beq taken / not taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick(); tick();
    chk("beq_t", 16'({state, pcen, pcsrc}), 16'b1000_1_01);
    zero = 1'b0;
    #1;
    chk("beq_nt", 16'({state, pcen}), 16'b1000_0);
    tick();
    // fetch stall, then illegal op
    memready = 1'b0; op = 6'b111111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("f_stall", 16'({state, irwrite, pcen}), 16'b0000_0_0);
      tick();
    end
    memready = 1'b1;
    tick(); chk("ill_dec", 16'({state, illegal}), 16'b0001_1);
    tick(); chk("ill_next", 16'({state, illegal}), 16'b0000_0);
    // async reset during MEMRD
    op = 6'b100011;
    tick(); tick();
    memready = 1'b0;
    tick(); chk("pre_rst", 16'(state), 16'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst", 16'({state, regwrite, memwrite, irwrite, pcen}), 16'b0000_0000);
    tick();
    reset = 1'b1; memready = 1'b1; op = 6'b000101; zero = 1'b0;
    tick();
`ifdef MULTICYCLE_BNE_EN
    tick(); chk("bne", 16'({state, pcen}), 16'b1100_1);
`else
    chk("bne_ill", 16'({state, illegal}), 16'b0001_1);
    tick(); chk("bne_ill_nx", 16'(state), 16'd0);
`endif

    // randomized phase
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mstate = 0;
    plan.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (mstate == 0) begin
        case ($urandom_range(0, 7))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b001000;
          5: op = 6'b000010;
          6: op = 6'b000101;
          default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0: funct = 6'b100000;
          1: funct = 6'b100010;
          2: funct = 6'b100100;
          3: funct = 6'b100101;
          4: funct = 6'b101010;
          default: funct = 6'($urandom);
        endcase
      end
      memready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        #1;
        check_model("rand_reset");
        mstate = 0;
        plan.delete();
        tick();
        reset = 1'b1;
        continue;
      end
      #1;
      check_model("rand");
      @(posedge clk);
      model_advance();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
